prefetch_unit: RTL
==================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 The block SHALL take parameter XLEN, default 32: width of all PC, address, immediate and register-operand values.
REQ-002 The block SHALL take parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-003 The block SHALL take parameter DEPTH, default 2, power of two from 2 to 8: instruction buffer entries.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  reset, asynchronous and active-high.
REQ-006 imem_req_o  out  1  fetch request strobe, one cycle per request.
REQ-007 imem_addr_o  out  XLEN  word address of the request, valid while imem_req_o=1.
REQ-008 imem_rvalid_i  in  1  response strobe; arrives 1 or more cycles after the request.
REQ-009 imem_rdata_i  in  32  instruction word, valid with imem_rvalid_i.
REQ-010 instr_valid_o / instr_o[32] / instr_pc_o[XLEN]  out  buffer head: valid flag, instruction word, its PC.
REQ-011 instr_ready_i  in  1  consumer accepts the head when instr_valid_o=1.
REQ-012 BE_i, UJE_i, JALRE_i  in  1 each  branch-taken, JAL and JALR redirect enables.
REQ-013 ex_pc_i, immed_i, R1_i  in  XLEN each  PC of the redirecting instruction, its immediate, and rs1 value.
REQ-014 RGD_o  out  XLEN  registered link value (rd write data); link_valid_o  out  1  one-cycle strobe when RGD_o updates.
REQ-015 misalign_o  out  1  one-cycle strobe when a redirect target has bit 1 set.

Function
REQ-016 At most one memory request SHALL be outstanding; FSM states are IDLE (none outstanding), WAIT (one outstanding) and DROP (one outstanding whose response is to be discarded).
REQ-017 In IDLE with no redirect and (buffer count + 0) < DEPTH, the block SHALL pulse imem_req_o with imem_addr_o=fetch_pc and enter WAIT.
REQ-018 In WAIT, on imem_rvalid_i the block SHALL push {imem_rdata_i, fetch_pc} into the buffer, set fetch_pc to fetch_pc+4 (modulo 2^XLEN) and return to IDLE; a request is issued no earlier than the next cycle.
REQ-019 A request SHALL only be issued when a free entry is guaranteed, so a push never occurs into a full buffer.
REQ-020 Redirect priority SHALL be BE_i > UJE_i > JALRE_i.
REQ-021 Redirect targets: BE_i and UJE_i -> ex_pc_i + {immed_i[XLEN-2:0],1'b0}; JALRE_i -> (R1_i + immed_i) with bit 0 cleared.
REQ-022 On a redirect the block SHALL, in the same edge, load fetch_pc with the target, empty the buffer, and go to DROP if in WAIT without a same-cycle response, else to IDLE.
REQ-023 In DROP the next imem_rvalid_i SHALL be discarded (no push, fetch_pc unchanged) and the FSM SHALL enter IDLE.
REQ-024 A response arriving in WAIT in the same cycle as a redirect SHALL be discarded.
REQ-025 On UJE_i or JALRE_i (when selected) RGD_o SHALL register ex_pc_i+4 and link_valid_o SHALL pulse for one cycle; BE_i leaves RGD_o unchanged.
REQ-026 misalign_o SHALL pulse in the cycle after a redirect whose target bit 1 is set; the redirect is still applied.
REQ-027 instr_valid_o SHALL equal buffer-not-empty; a pop occurs on instr_valid_o & instr_ready_i; a pop and a redirect in the same cycle SHALL result in an empty buffer.
REQ-028 Simultaneous push and pop SHALL leave the count unchanged; read and write pointers wrap modulo DEPTH.

Reset
REQ-029 While rst_i=1: fetch_pc=RESET_PC, FSM=IDLE, buffer empty, imem_req_o=0, instr_valid_o=0, RGD_o=0, link_valid_o=0, misalign_o=0.
REQ-030 A response arriving while in reset or in the first cycle after reset SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, WAIT, DROP) and the instruction-buffer entry struct {instr, pc}.
REQ-032 The buffer SHALL be a sub-module named prefetch_fifo, parametrised by DEPTH and entry width.

Verification
REQ-033 Reset, memory responds 1 cycle after each request, ready=1 -> instr_pc_o sequence 0x0, 0x4, 0x8 with matching instr_o.
REQ-034 ready=0, DEPTH=2 -> exactly 2 requests (0x0, 0x4), then imem_req_o stays 0 until a pop.
REQ-035 BE_i with ex_pc_i=0x10, immed_i=0x8 while a request is outstanding -> that response is dropped, next imem_addr_o=0x20, buffer empty.
REQ-036 JALRE_i with R1_i=0x101, immed_i=0x4, ex_pc_i=0x40 -> next imem_addr_o=0x104, RGD_o=0x44, link_valid_o pulses once.
REQ-037 BE_i and JALRE_i together, ex_pc_i=0x0, immed_i=0x3 -> target 0x6, misalign_o pulses, RGD_o unchanged.
REQ-038 fetch_pc=0xFFFF_FFFC fetch -> next imem_addr_o=0x0.

Source files
------------

// File: rtl/prefetch_unit_pkg.sv
// Shared types for the instruction prefetch unit: fetch FSM states and the
// instruction-buffer entry layout.
package prefetch_unit_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned XLEN_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } pf_state_e;

  // pc is sized for the widest supported XLEN; narrower configs zero-extend.
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [XLEN_MAX-1:0] pc;
  } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Instruction buffer: power-of-two circular FIFO with flush; flush beats push and pop.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 96,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [CW-1:0]    w_count_nxt;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~i_flush;
  assign w_pop  = i_pop & r_valid & ~i_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  // Storage needs no reset; r_valid gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_valid = r_valid;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: single-outstanding fetch FSM feeding a small
// instruction buffer, with branch/JAL/JALR redirect and link-value generation.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  input  logic            BE_i,
  input  logic            UJE_i,
  input  logic            JALRE_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] immed_i,
  input  logic [XLEN-1:0] R1_i,
  output logic [XLEN-1:0] RGD_o,
  output logic            link_valid_o,
  output logic            misalign_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = $bits(pf_entry_t);

  pf_state_e           r_state;
  logic [XLEN-1:0]     r_fetch_pc;
  logic [XLEN-1:0]     r_addr;
  logic [XLEN-1:0]     r_rgd;
  logic                r_req;
  logic                r_link_valid;
  logic                r_misalign;

  logic                w_redirect;
  logic                w_link;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_valid;
  logic [XLEN-1:0]     w_br_off;
  logic [XLEN-1:0]     w_target;
  logic [CW-1:0]       w_count;
  pf_entry_t           w_push_entry;
  pf_entry_t           w_head;
  logic [INSTR_W-1:0]  w_head_instr;
  logic [XLEN_MAX-1:0] w_head_pc;

  assign w_redirect = BE_i | UJE_i | JALRE_i;
  assign w_link     = ~BE_i & (UJE_i | JALRE_i);
  assign w_br_off   = {immed_i[XLEN-2:0], 1'b0};

  // Branch/JAL are PC-relative; JALR is register-relative with bit 0 cleared.
  always_comb begin
    w_target = (R1_i + immed_i) & ~XLEN'(1);
    if (BE_i || UJE_i) begin
      w_target = ex_pc_i + w_br_off;
    end
  end

  assign w_push = (r_state == WAIT) & imem_rvalid_i & ~w_redirect;
  assign w_pop  = w_fifo_valid & instr_ready_i;

  assign w_push_entry = '{instr: imem_rdata_i, pc: XLEN_MAX'(r_fetch_pc)};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_addr       <= RESET_PC;
      r_rgd        <= '0;
      r_req        <= 1'b0;
      r_link_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_req        <= 1'b0;
      r_link_valid <= 1'b0;
      r_misalign   <= 1'b0;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_misalign <= w_target[1];
        if (w_link) begin
          r_rgd        <= ex_pc_i + XLEN'(4);
          r_link_valid <= 1'b1;
        end
        // An in-flight request without a same-cycle response must be discarded later.
        if ((r_state == WAIT || r_state == DROP) && !imem_rvalid_i) begin
          r_state <= DROP;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_count < CW'(DEPTH)) begin
              r_req   <= 1'b1;
              r_addr  <= r_fetch_pc;
              r_state <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid_i) begin
              r_fetch_pc <= r_fetch_pc + XLEN'(4);
              r_state    <= IDLE;
            end
          end
          DROP: begin
            if (imem_rvalid_i) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (w_redirect),
    .o_valid     (w_fifo_valid),
    .o_data      (w_head),
    .o_count     (w_count)
  );

  assign {w_head_instr, w_head_pc} = w_head;

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign instr_valid_o = w_fifo_valid;
  assign instr_o       = w_head_instr;
  assign instr_pc_o    = XLEN'(w_head_pc);
  assign RGD_o         = r_rgd;
  assign link_valid_o  = r_link_valid;
  assign misalign_o    = r_misalign;

endmodule
